turn_arbiter: RTL and testbench
===============================

# turn_arbiter

Turn scheduler for the two-tank artillery game. It owns the shared keyboard keycode and the single shell/projectile resource. It grants keyboard control to exactly one tank at a time, enforces a per-turn frame budget, and holds both tanks idle while a shell is in flight. It then settles the outcome (next turn or game over). It sits between the keyboard/USB keycode source and the two tank blocks, and drives the projectile block's fire request.

## Interface
Parameters:
- MOVE_FRAMES, 300: frames per turn (5 s at 60 Hz); must fit 9 bits.
- SHELL_TIMEOUT, 240: max frames a shell may fly before forced settle; must fit 8 bits.
- RESTART_KEY, 8'h28: keycode (Enter) that restarts from game over.

Ports:
- frame_clk  in  1  frame clock; the only clock.
- Reset  in  1  reset, synchronous and active-high.
- keycode  in  8  raw keycode from keyboard interface.
- shoot_a / shoot_b  in  1  shoot pulse from tank A / tank B.
- shell_done  in  1  one-frame pulse from projectile block: shell landed or left screen.
- hp_a / hp_b  in  4  current HP of tank A / B.
- keycode_a / keycode_b  out  8  gated keycode to tank A / B.
- active  out  1  player holding the turn (0 = A, 1 = B).
- shell_fire  out  1  one-frame launch request to projectile block.
- shell_owner  out  1  tank that fired the current shell.
- timer  out  9  frames remaining in current turn.
- phase  out  2  state: 0 TURN, 1 FLIGHT, 2 SETTLE, 3 OVER.
- game_over  out  1  high in OVER.
- winner  out  1  valid when game_over (0 = A, 1 = B).

## Operation
- States:
  - TURN: keycode_a = keycode when active==0, else 0; keycode_b symmetric. Combinational gating; the other tank always sees 0.
  - FLIGHT, SETTLE, OVER: both gated keycodes are 0.
- TURN:
  - timer decrements by 1 each frame.
  - Shoot pulse from the active tank -> FLIGHT. That frame: shell_fire=1, shell_owner=active, flight counter cleared.
  - Shoot pulse from the inactive tank is ignored.
  - timer==0 with no shoot -> turn forfeited: active toggles, timer reloads MOVE_FRAMES, stay in TURN.
- FLIGHT:
  - Flight counter (8 bit) increments each frame.
  - Any frame with hp_a==0 sets dead_a; any frame with hp_b==0 sets dead_b. These are sticky. The tanks reload HP one frame after reaching 0, so this latching is mandatory.
  - shell_done, or flight counter==SHELL_TIMEOUT-1 -> SETTLE.
- SETTLE (one frame):
  - If dead_a or dead_b -> OVER. winner = B if only dead_a; A if only dead_b; shell_owner if both.
  - Otherwise -> TURN with active toggled and timer = MOVE_FRAMES.
  - Clear dead flags when leaving SETTLE for TURN.
- OVER:
  - game_over=1.
  - keycode==RESTART_KEY -> TURN with active=0, timer=MOVE_FRAMES, dead flags cleared, winner/game_over cleared.
- Reset values: phase TURN, active 0, timer MOVE_FRAMES, shell_fire 0, shell_owner 0, game_over 0, winner 0, dead flags 0, flight counter 0.

## Timing
- All state updates on posedge frame_clk. Reset is sampled synchronously and overrides everything, including mid-FLIGHT; a shell in flight is abandoned.
- shell_fire is high exactly one frame: the frame the FSM enters FLIGHT. It is registered, so it appears the frame after the shoot pulse is sampled.
- Key control lost in the same frame FLIGHT is entered.
- Shoot-to-next-turn latency:
  - 1 frame (TURN->FLIGHT) + flight frames + 1 frame SETTLE.
  - shell_done sampled at frame n -> phase=SETTLE at n+1, TURN at n+2.
- Simultaneous events:
  - Shoot and timer==0 in the same frame: shoot wins.
  - shell_done and timeout in the same frame: single SETTLE.
  - hp==0 in the same frame as shell_done: still latched.
- timer does not wrap: holds 0 only for the expiry frame, then reloads.
- Arithmetic: timer 9-bit unsigned, flight counter 8-bit unsigned, no signed math.

## Test plan
- Reset, keycode=8'h04 held: keycode_a=8'h04, keycode_b=0, active=0, timer=300 then decrementing 299, 298…
- Tank A shoot pulse at frame 10: phase=FLIGHT, shell_fire=1 for one frame, shell_owner=0, keycode_a=0. shell_done at frame 50: SETTLE at 51, TURN at 52 with active=1, timer=300.
- No input for 300 frames: at expiry active toggles to 1, timer=300, phase stays TURN.
- In FLIGHT, hp_b=0 for one frame then 10, then shell_done: phase=OVER, game_over=1, winner=0. keycode=8'h28: TURN, active=0, game_over=0.
- shell_done never arrives: FLIGHT lasts exactly 240 frames, then SETTLE, then TURN with active toggled.
- Reset asserted mid-FLIGHT: next frame phase=TURN, active=0, timer=300, shell_fire=0, game_over=0.

Source files
------------

// File: rtl/turn_arbiter.sv
// Turn scheduler for the two-tank artillery game.
// Grants the shared keycode to one tank at a time, runs the per-turn frame
// budget, owns the single shell while it flies, and settles the round outcome.
//
// state  | meaning
// -------+-------------------------------------------------------------
// TURN   | active tank steers; timer counts down; shoot launches shell
// FLIGHT | shell airborne; both tanks locked out; hp==0 latched sticky
// SETTLE | one frame: decide next turn or game over from dead flags
// OVER   | game over; winner valid; waiting for the restart keycode
module turn_arbiter #(
    parameter int          MOVE_FRAMES   = 300,
    parameter int          SHELL_TIMEOUT = 240,
    parameter logic [7:0]  RESTART_KEY   = 8'h28
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       shoot_a,
    input  logic       shoot_b,
    input  logic       shell_done,
    input  logic [3:0] hp_a,
    input  logic [3:0] hp_b,
    output logic [7:0] keycode_a,
    output logic [7:0] keycode_b,
    output logic       active,
    output logic       shell_fire,
    output logic       shell_owner,
    output logic [8:0] timer,
    output logic [1:0] phase,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [1:0] {
        TURN   = 2'd0,
        FLIGHT = 2'd1,
        SETTLE = 2'd2,
        OVER   = 2'd3
    } phase_t;

    localparam logic [8:0] TIMER_RELOAD = 9'(MOVE_FRAMES);
    localparam logic [7:0] FLIGHT_LAST  = 8'(SHELL_TIMEOUT - 1);

    phase_t     state, state_n;
    logic [7:0] flight_cnt, flight_cnt_n;
    logic       dead_a, dead_a_n;
    logic       dead_b, dead_b_n;
    logic       active_n;
    logic [8:0] timer_n;
    logic       fire_n;
    logic       owner_n;
    logic       winner_n;
    logic       shoot_act;

    // Only the tank holding the turn may launch.
    assign shoot_act = active ? shoot_b : shoot_a;

    // Keyboard gating follows the registered state, so control drops the
    // same frame FLIGHT is entered.
    assign keycode_a = (state == TURN && !active) ? keycode : 8'h00;
    assign keycode_b = (state == TURN &&  active) ? keycode : 8'h00;
    assign phase     = state;
    assign game_over = (state == OVER);

    // State register and all registered datapath values.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state       <= TURN;
            active      <= 1'b0;
            timer       <= TIMER_RELOAD;
            shell_fire  <= 1'b0;
            shell_owner <= 1'b0;
            winner      <= 1'b0;
            dead_a      <= 1'b0;
            dead_b      <= 1'b0;
            flight_cnt  <= 8'd0;
        end else begin
            state       <= state_n;
            active      <= active_n;
            timer       <= timer_n;
            shell_fire  <= fire_n;
            shell_owner <= owner_n;
            winner      <= winner_n;
            dead_a      <= dead_a_n;
            dead_b      <= dead_b_n;
            flight_cnt  <= flight_cnt_n;
        end
    end

    // Next-state and next-datapath decode.
    always_comb begin
        state_n      = state;
        active_n     = active;
        timer_n      = timer;
        fire_n       = 1'b0;
        owner_n      = shell_owner;
        winner_n     = winner;
        dead_a_n     = dead_a;
        dead_b_n     = dead_b;
        flight_cnt_n = flight_cnt;

        unique case (state)
            TURN: begin
                // A shoot beats an expiring timer in the same frame; the
                // timer is frozen while the shell is out.
                if (shoot_act) begin
                    state_n      = FLIGHT;
                    fire_n       = 1'b1;
                    owner_n      = active;
                    flight_cnt_n = 8'd0;
                end else if (timer == 9'd0) begin
                    active_n = ~active;
                    timer_n  = TIMER_RELOAD;
                end else begin
                    timer_n = timer - 9'd1;
                end
            end
            FLIGHT: begin
                // Tanks reload HP one frame after hitting 0, so latch it.
                if (hp_a == 4'd0) dead_a_n = 1'b1;
                if (hp_b == 4'd0) dead_b_n = 1'b1;
                flight_cnt_n = flight_cnt + 8'd1;
                if (shell_done || flight_cnt == FLIGHT_LAST) begin
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (dead_a || dead_b) begin
                    state_n = OVER;
                    if (dead_a && dead_b) winner_n = shell_owner;
                    else                  winner_n = dead_a;
                end else begin
                    state_n  = TURN;
                    active_n = ~active;
                    timer_n  = TIMER_RELOAD;
                    dead_a_n = 1'b0;
                    dead_b_n = 1'b0;
                end
            end
            OVER: begin
                if (keycode == RESTART_KEY) begin
                    state_n  = TURN;
                    active_n = 1'b0;
                    timer_n  = TIMER_RELOAD;
                    winner_n = 1'b0;
                    dead_a_n = 1'b0;
                    dead_b_n = 1'b0;
                end
            end
            default: state_n = TURN;
        endcase
    end

endmodule

// File: tb/tb_turn_arbiter.sv
// Bench for turn_arbiter: a frame-level reference model pushes the expected
// outputs for each frame into a scoreboard queue; they are popped and
// compared one time unit after the frame edge.
module tb_turn_arbiter;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic       shoot_a, shoot_b, shell_done;
    logic [3:0] hp_a, hp_b;
    logic [7:0] keycode_a, keycode_b;
    logic       active, shell_fire, shell_owner, game_over, winner;
    logic [8:0] timer;
    logic [1:0] phase;

    turn_arbiter dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .shoot_a    (shoot_a),
        .shoot_b    (shoot_b),
        .shell_done (shell_done),
        .hp_a       (hp_a),
        .hp_b       (hp_b),
        .keycode_a  (keycode_a),
        .keycode_b  (keycode_b),
        .active     (active),
        .shell_fire (shell_fire),
        .shell_owner(shell_owner),
        .timer      (timer),
        .phase      (phase),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct packed {
        logic [1:0] phase;
        logic       active;
        logic [8:0] timer;
        logic       fire;
        logic       owner;
        logic       go;
        logic       winner;
        logic [7:0] ka;
        logic [7:0] kb;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   fl_frames;
    int   fire_cnt;

    // Reference model state.
    int   m_phase;
    bit   m_active, m_fire, m_owner, m_winner, m_dead_a, m_dead_b;
    int   m_timer, m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one frame from the current inputs.
    task automatic model_step();
        bit shoot;
        if (Reset) begin
            m_phase = 0; m_active = 0; m_timer = 300; m_fire = 0; m_owner = 0;
            m_winner = 0; m_dead_a = 0; m_dead_b = 0; m_cnt = 0;
            return;
        end
        m_fire = 0;
        if (m_phase == 0) begin
            shoot = (m_active == 0) ? shoot_a : shoot_b;
            if (shoot) begin
                m_phase = 1; m_fire = 1; m_owner = m_active; m_cnt = 0;
            end else if (m_timer == 0) begin
                m_active = !m_active; m_timer = 300;
            end else begin
                m_timer = m_timer - 1;
            end
        end else if (m_phase == 1) begin
            if (hp_a == 0) m_dead_a = 1;
            if (hp_b == 0) m_dead_b = 1;
            if (shell_done || m_cnt == 239) m_phase = 2;
            m_cnt = m_cnt + 1;
        end else if (m_phase == 2) begin
            if (m_dead_a || m_dead_b) begin
                m_phase = 3;
                m_winner = (m_dead_a && m_dead_b) ? m_owner : (m_dead_a ? 1'b1 : 1'b0);
            end else begin
                m_phase = 0; m_active = !m_active; m_timer = 300;
                m_dead_a = 0; m_dead_b = 0;
            end
        end else begin
            if (keycode == 8'h28) begin
                m_phase = 0; m_active = 0; m_timer = 300; m_winner = 0;
                m_dead_a = 0; m_dead_b = 0;
            end
        end
    endtask

    // One frame: model, push expectation, clock, pop and compare.
    task automatic tick();
        exp_t e;
        model_step();
        e.phase  = 2'(m_phase);
        e.active = m_active;
        e.timer  = 9'(m_timer);
        e.fire   = m_fire;
        e.owner  = m_owner;
        e.go     = (m_phase == 3);
        e.winner = m_winner;
        e.ka     = (m_phase == 0 && !m_active) ? keycode : 8'h00;
        e.kb     = (m_phase == 0 &&  m_active) ? keycode : 8'h00;
        sb_q.push_back(e);
        @(posedge frame_clk);
        #1;
        e = sb_q.pop_front();
        chk("phase",       32'(phase),       32'(e.phase));
        chk("active",      32'(active),      32'(e.active));
        chk("timer",       32'(timer),       32'(e.timer));
        chk("shell_fire",  32'(shell_fire),  32'(e.fire));
        chk("shell_owner", 32'(shell_owner), 32'(e.owner));
        chk("game_over",   32'(game_over),   32'(e.go));
        chk("winner",      32'(winner),      32'(e.winner));
        chk("keycode_a",   32'(keycode_a),   32'(e.ka));
        chk("keycode_b",   32'(keycode_b),   32'(e.kb));
        if (phase == 2'd1) fl_frames++;
        if (shell_fire)    fire_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_shoot(input bit b);
        if (b) shoot_b = 1'b1; else shoot_a = 1'b1;
        tick();
        shoot_a = 1'b0;
        shoot_b = 1'b0;
    endtask

    task automatic pulse_done();
        shell_done = 1'b1;
        tick();
        shell_done = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; keycode = 8'h04; shoot_a = 0; shoot_b = 0; shell_done = 0;
        hp_a = 4'd10; hp_b = 4'd10;
        fl_frames = 0; fire_cnt = 0;
        ticks(2);
        chk("rst_timer", 32'(timer), 32'd300);
        Reset = 1'b0;

        // Idle countdown, inactive-tank shoot ignored, A shoots at frame 10.
        ticks(5);
        chk("timer_295", 32'(timer), 32'd295);
        pulse_shoot(1'b1);
        ticks(3);
        fire_cnt = 0;
        pulse_shoot(1'b0);
        chk("fire_one", 32'(fire_cnt), 32'd1);
        ticks(39);
        pulse_done();
        chk("settle", 32'(phase), 32'd2);
        tick();
        chk("next_turn_b", 32'(active), 32'd1);
        chk("next_timer", 32'(timer), 32'd300);

        // Forfeit by timeout: 300 decrements then the expiry frame.
        ticks(300);
        chk("expiry_zero", 32'(timer), 32'd0);
        tick();
        chk("forfeit_active", 32'(active), 32'd0);

        // Shoot on the expiry frame wins over the forfeit.
        for (int i = 0; i < 400 && m_timer != 0; i++) tick();
        pulse_shoot(1'b0);
        chk("shoot_wins", 32'(phase), 32'd1);
        ticks(4);
        pulse_done();
        tick();

        // B fires, hp_b dips to 0 for one frame: A wins.
        ticks(3);
        pulse_shoot(1'b1);
        ticks(4);
        hp_b = 4'd0; tick(); hp_b = 4'd10;
        ticks(3);
        pulse_done();
        tick();
        chk("over_winner_a", 32'(winner), 32'd0);
        ticks(3);
        keycode = 8'h28; tick(); keycode = 8'h04;
        chk("restart_go", 32'(game_over), 32'd0);
        tick();

        // Shell that never lands: forced settle after 240 flight frames.
        fl_frames = 0;
        pulse_shoot(1'b0);
        ticks(250);
        chk("flight_len", 32'(fl_frames), 32'd240);

        // Both tanks die on the landing frame: shooter (B) wins.
        ticks(2);
        pulse_shoot(1'b1);
        ticks(3);
        hp_a = 4'd0; hp_b = 4'd0; shell_done = 1'b1;
        tick();
        hp_a = 4'd10; hp_b = 4'd10; shell_done = 1'b0;
        ticks(2);
        chk("both_dead_winner", 32'(winner), 32'd1);
        keycode = 8'h28; tick(); keycode = 8'h04;

        // Reset in mid-flight abandons the shell.
        ticks(2);
        pulse_shoot(1'b0);
        ticks(5);
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("rst_flight_phase", 32'(phase), 32'd0);
        ticks(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
